// File: rtl/interface_botoes.sv
// interface_botoes: conditions the raw asynchronous button vector for the
// memory game. It synchronises, debounces and validates presses, then emits
// one registered play code plus a single-cycle pulse per physical press.
// Optional feature macro: BOTOES_CONTA_JOGADAS_EN adds the db_num_jogadas
// counter of accepted plays.
module interface_botoes #(
   parameter int N_BOTOES        = 4,
   parameter int DEBOUNCE_CICLOS = 1000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_BOTOES-1:0] botoes,
   input  logic                habilita,
   output logic [N_BOTOES-1:0] jogada,
   output logic                jogada_feita,
   output logic                erro_multiplo,
   output logic                algum_pressionado,
   output logic [2:0]          db_estado
`ifdef BOTOES_CONTA_JOGADAS_EN
   ,
   output logic [7:0]          db_num_jogadas
`endif
);

   localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
   localparam logic [CW-1:0]       CNT_ALVO = CW'(DEBOUNCE_CICLOS);
   localparam logic [CW-1:0]       CNT_UM   = CW'(1);
   localparam logic [N_BOTOES-1:0] UM_B     = N_BOTOES'(1);

   typedef enum logic [2:0] {
      OCIOSO        = 3'b000,
      FILTRA_PRESS  = 3'b001,
      ACEITA        = 3'b010,
      ESPERA_SOLTAR = 3'b011,
      FILTRA_SOLTA  = 3'b100,
      INVALIDO      = 3'b101
   } estado_t;

   estado_t             estado, prox_estado;
   logic [N_BOTOES-1:0] b_meta, b_sync;
   logic [N_BOTOES-1:0] amostra, prox_amostra;
   logic [CW-1:0]       cnt, prox_cnt;
   logic                filtro_ok;
   logic                multiplo;
   logic                prox_algum;

   // Counter stops at the target so a long hold can never wrap it.
   function automatic logic [CW-1:0] incr_sat(input logic [CW-1:0] c);
      return (c >= CNT_ALVO) ? c : c + CNT_UM;
   endfunction

   assign filtro_ok = (cnt >= CNT_ALVO);
   // More than one bit set <=> clearing the lowest set bit leaves something.
   assign multiplo  = |(amostra & (amostra - UM_B));
   assign db_estado = estado;

   // Two-flop synchroniser on every button line.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         b_meta <= '0;
         b_sync <= '0;
      end else begin
         b_meta <= botoes;
         b_sync <= b_meta;
      end
   end

   // Next-state logic: press filter, decision, release filter.
   always_comb begin
      prox_estado  = estado;
      prox_amostra = amostra;
      prox_cnt     = cnt;
      case (estado)
         OCIOSO: begin
            if (b_sync != '0) begin
               prox_amostra = b_sync;
               prox_cnt     = CNT_UM;
               prox_estado  = FILTRA_PRESS;
            end
         end
         FILTRA_PRESS: begin
            // Once enough stable samples are in, decide without looking at
            // the current sample; habilita matters only in this cycle.
            if (filtro_ok) begin
               if (multiplo)      prox_estado = INVALIDO;
               else if (habilita) prox_estado = ACEITA;
               else               prox_estado = ESPERA_SOLTAR;
            end else if (b_sync != amostra) begin
               if (b_sync == '0) begin
                  prox_estado = OCIOSO;
               end else begin
                  prox_amostra = b_sync;
                  prox_cnt     = CNT_UM;
               end
            end else begin
               prox_cnt = incr_sat(cnt);
            end
         end
         ACEITA, INVALIDO: prox_estado = ESPERA_SOLTAR;
         ESPERA_SOLTAR: begin
            if (b_sync == '0) begin
               prox_cnt    = CNT_UM;
               prox_estado = FILTRA_SOLTA;
            end
         end
         FILTRA_SOLTA: begin
            if (filtro_ok)          prox_estado = OCIOSO;
            else if (b_sync != '0)  prox_estado = ESPERA_SOLTAR;
            else                    prox_cnt    = incr_sat(cnt);
         end
         default: prox_estado = OCIOSO;
      endcase
   end

   // Debounced "any button down" level, evaluated on the upcoming state.
   always_comb begin
      prox_algum = 1'b0;
      case (prox_estado)
         FILTRA_PRESS:                                   prox_algum = (prox_cnt >= CNT_ALVO);
         ACEITA, INVALIDO, ESPERA_SOLTAR, FILTRA_SOLTA:  prox_algum = 1'b1;
         default:                                        prox_algum = 1'b0;
      endcase
   end

   // State, filter registers and registered outputs (aligned with the state).
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado            <= OCIOSO;
         amostra           <= '0;
         cnt               <= '0;
         jogada            <= '0;
         jogada_feita      <= 1'b0;
         erro_multiplo     <= 1'b0;
         algum_pressionado <= 1'b0;
      end else begin
         estado            <= prox_estado;
         amostra           <= prox_amostra;
         cnt               <= prox_cnt;
         jogada_feita      <= (prox_estado == ACEITA);
         erro_multiplo     <= (prox_estado == INVALIDO);
         algum_pressionado <= prox_algum;
         if (prox_estado == ACEITA) jogada <= amostra;
      end
   end

`ifdef BOTOES_CONTA_JOGADAS_EN
   // Accepted-play counter, wraps naturally at 8 bits.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                       db_num_jogadas <= 8'd0;
      else if (prox_estado == ACEITA)  db_num_jogadas <= db_num_jogadas + 8'd1;
   end
`endif

endmodule
